fetch_align: RTL and testbench
==============================

Name: fetch_align

Overview:
- Instruction realignment buffer between the fetch stage and stage2_decode in the RV32IMC pipeline.
- Takes word-aligned 32-bit fetch words and repacks them into instructions: 16-bit compressed instructions, 32-bit instructions, and 32-bit instructions that straddle a word boundary.
- Tracks the instruction PC itself and presents one instruction per cycle with a valid/ready handshake to decode.
- Handles redirects to halfword-aligned targets and propagates fetch access faults.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_VECTOR, 32'h8000_0000, PC after reset; bit 1 honoured, bit 0 ignored.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- fetch_valid_i  input  1  fetch word valid
- fetch_data_i  input  32  fetch word; low halfword at the lower address
- fetch_err_i  input  1  access fault on this fetch word
- fetch_ready_o  output  1  buffer can accept a word this cycle
- flush_i  input  1  redirect; discard all buffered state
- flush_pc_i  input  XLEN  redirect target; halfword aligned
- inst_valid_o  output  1  aligned instruction available
- inst_ready_i  input  1  decode accepts the instruction
- inst_o  output  32  instruction; compressed occupies [15:0] with [31:16]=0
- pc_o  output  XLEN  PC of inst_o
- is_comp_o  output  1  inst_o is 16-bit
- inst_err_o  output  1  instruction fault (any halfword it uses faulted)

Behaviour:
- Clock clk_i; one clock domain; reset rst_i is synchronous and active-high. All state is updated on the rising edge.
- State:
  - halfword queue, 4 entries × (16 data + 1 err bit);
  - count_q, range 0..4;
  - pc_q;
  - drop_q, discard the low halfword of the next accepted word.
- Reset:
  - count_q=0, pc_q=RESET_VECTOR with bit0 cleared, drop_q=RESET_VECTOR[1].
  - Outputs: inst_valid_o=0, inst_o=0, pc_o=pc_q, is_comp_o=0, inst_err_o=0, fetch_ready_o=1.
- fetch_ready_o = (count_q <= 2). It depends on registered state only, with no combinational path from inst_ready_i.
- Push: on fetch_valid_i & fetch_ready_o & !flush_i:
  - append 2 halfwords, low then high, each tagged with fetch_err_i;
  - if drop_q, append the high halfword only, then clear drop_q.
- Head classification: h0 = head halfword. It is compressed when h0[1:0]!=2'b11.
- Output valid (combinational from queue state; latency from push to output is 1 cycle):
  - count_q>=1 and (compressed or h0.err); or
  - count_q>=2.
- Output contents:
  - compressed: inst_o={16'b0,h0}, is_comp_o=1, consume 1 halfword, inst_err_o=h0.err;
  - otherwise: inst_o={h1,h0}, is_comp_o=0, consume 2, inst_err_o=h0.err|h1.err;
  - if h0.err and count_q==1 (uncompressed): output with inst_err_o=1, is_comp_o=0, inst_o={16'b0,h0}, consume 1. The fault must never stall.
  - when inst_valid_o=0: inst_o=0, is_comp_o=0, inst_err_o=0.
- Pop: on inst_valid_o & inst_ready_i, remove the consumed halfwords and set pc_q += 2 or 4 (mod 2^XLEN).
- Simultaneous push and pop in the same cycle: new count = count_q + pushed − popped. Ordering is preserved; the remaining halfwords shift to the head.
- inst_o, pc_o, is_comp_o and inst_err_o hold stable while inst_valid_o=1 and inst_ready_i=0.
- Flush has priority over push and pop in the same cycle:
  - count_q=0, pc_q={flush_pc_i[XLEN-1:1],1'b0}, drop_q=flush_pc_i[1];
  - a concurrent fetch word is discarded;
  - inst_valid_o is forced to 0 in the flush cycle.
- Fetch must supply sequential words starting at the word containing the flush target. The block does not check fetch addresses.
- count_q never exceeds 4. Overflow is impossible by construction because of the ready rule; the bench asserts this.

Test Plan:
- Reset, fetch 32'h0000_0513 (addi x10,x0,0) → next cycle inst_valid_o=1, inst_o=32'h0000_0513, pc_o=32'h8000_0000, is_comp_o=0; after pop, pc_q=32'h8000_0004.
- Fetch 32'h4501_4501 (two c.li) → two outputs: inst_o=32'h0000_4501 at pc 8000_0000 and 8000_0002, is_comp_o=1 each.
- Straddle: words 32'h0513_4501 then 32'hxxxx_0000 → c.li at 8000_0000, then inst_o=32'h0000_0513 at 8000_0002; valid only after the second word arrives.
- flush_i with flush_pc_i=32'h8000_0102, then fetch 32'h4505_FFFF → low halfword dropped; inst_o=32'h0000_4505, pc_o=32'h8000_0102. A same-cycle pop is ignored.
- Backpressure: inst_ready_i=0 while pushing 32'h4501_4501 → count_q reaches 2 then 4, fetch_ready_o drops to 0, outputs stay stable; release drains 4 c.li in order.
- Fault: fetch_err_i=1 with data 32'h0000_0013 after a buffered 16'h0513 → straddled instruction has inst_err_o=1. A lone faulting halfword 16'hFFFF at count 1 → valid with inst_err_o=1, no stall.

Source files
------------

// File: rtl/fetch_align.sv
// -----------------------------------------------------------------------------
// fetch_align
// Instruction realignment buffer between fetch and decode (RV32IMC).
// Word-aligned 32-bit fetch words are split into halfwords and queued. The
// head of the queue is presented to decode as one instruction:
//   - 16-bit compressed (head halfword bits [1:0] != 2'b11),
//   - 32-bit (head + next halfword, possibly from two fetch words), or
//   - a lone faulting halfword that cannot be completed (so a fault never stalls).
// The block keeps the PC of the head instruction. A redirect (flush) discards
// all buffered halfwords. A redirect to an odd halfword drops the low half of
// the next accepted fetch word.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   fetch_valid_i         fetch word valid
//   fetch_data_i [31:0]   fetch word, low halfword at the lower address
//   fetch_err_i           access fault on this fetch word
//   fetch_ready_o         buffer can take a word (registered state only)
//   flush_i               redirect, highest priority
//   flush_pc_i [XLEN-1:0] redirect target (halfword aligned)
//   inst_valid_o          aligned instruction available
//   inst_ready_i          decode accepts the instruction
//   inst_o [31:0]         instruction; compressed in [15:0], upper bits zero
//   pc_o [XLEN-1:0]       PC of inst_o
//   is_comp_o             inst_o is a 16-bit instruction
//   inst_err_o            a halfword used by inst_o faulted
// -----------------------------------------------------------------------------
module fetch_align #(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(32'h8000_0000)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            fetch_valid_i,
   input  logic [31:0]     fetch_data_i,
   input  logic            fetch_err_i,
   output logic            fetch_ready_o,
   input  logic            flush_i,
   input  logic [XLEN-1:0] flush_pc_i,
   output logic            inst_valid_o,
   input  logic            inst_ready_i,
   output logic [31:0]     inst_o,
   output logic [XLEN-1:0] pc_o,
   output logic            is_comp_o,
   output logic            inst_err_o
);

   localparam int DEPTH = 4;

   // Queue entry layout: [16] = fault flag, [15:0] = halfword.
   logic [16:0]     r_q [0:DEPTH-1];
   logic [2:0]      r_count;
   logic [XLEN-1:0] r_pc;
   logic            r_drop;

   logic [16:0]     w_h0;
   logic [16:0]     w_h1;
   logic            w_h0_comp;
   logic            w_have1;
   logic            w_have2;
   logic            w_valid;
   logic [1:0]      w_cons;
   logic            w_pop;
   logic [1:0]      w_npop;
   logic            w_ready;
   logic            w_push;
   logic [1:0]      w_npush;
   logic [16:0]     w_push0;
   logic [16:0]     w_push1;
   logic [2:0]      w_rem;
   logic [2:0]      w_rem_p1;
   logic [16:0]     w_qnext [0:DEPTH-1];

   assign w_h0      = r_q[0];
   assign w_h1      = r_q[1];
   assign w_h0_comp = (w_h0[1:0] != 2'b11);
   assign w_have1   = (r_count != 3'd0);
   assign w_have2   = (r_count >= 3'd2);

   // A faulting head halfword is emitted even when its partner never arrives.
   assign w_valid = !flush_i && ((w_have1 && (w_h0_comp || w_h0[16])) || w_have2);

   always_comb begin
      inst_o     = 32'h0;
      is_comp_o  = 1'b0;
      inst_err_o = 1'b0;
      w_cons     = 2'd0;
      if (w_valid) begin
         if (w_h0_comp) begin
            inst_o     = {16'h0, w_h0[15:0]};
            is_comp_o  = 1'b1;
            inst_err_o = w_h0[16];
            w_cons     = 2'd1;
         end else if (!w_have2) begin
            // Lone faulting first half of a 32-bit instruction.
            inst_o     = {16'h0, w_h0[15:0]};
            inst_err_o = 1'b1;
            w_cons     = 2'd1;
         end else begin
            inst_o     = {w_h1[15:0], w_h0[15:0]};
            inst_err_o = w_h0[16] | w_h1[16];
            w_cons     = 2'd2;
         end
      end
   end

   assign inst_valid_o  = w_valid;
   assign pc_o          = r_pc;

   // At most two halfwords are appended per cycle, so count <= 2 guarantees
   // space regardless of what decode does this cycle.
   assign w_ready       = (r_count <= 3'd2);
   assign fetch_ready_o = w_ready;

   assign w_pop   = w_valid && inst_ready_i;
   assign w_npop  = w_pop ? w_cons : 2'd0;
   assign w_push  = fetch_valid_i && w_ready && !flush_i;
   assign w_npush = !w_push ? 2'd0 : (r_drop ? 2'd1 : 2'd2);

   // With a pending drop the high halfword becomes the first appended entry.
   assign w_push0 = r_drop ? {fetch_err_i, fetch_data_i[31:16]}
                           : {fetch_err_i, fetch_data_i[15:0]};
   assign w_push1 = {fetch_err_i, fetch_data_i[31:16]};

   // Entries surviving the pop; new halfwords land right behind them.
   assign w_rem    = r_count - {1'b0, w_npop};
   assign w_rem_p1 = w_rem + 3'd1;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [16:0] w_sh1;
         logic [16:0] w_sh2;
         logic [16:0] w_shift;

         if (gi + 1 < DEPTH) begin : g_s1
            assign w_sh1 = r_q[gi+1];
         end else begin : g_s1z
            assign w_sh1 = 17'h0;
         end

         if (gi + 2 < DEPTH) begin : g_s2
            assign w_sh2 = r_q[gi+2];
         end else begin : g_s2z
            assign w_sh2 = 17'h0;
         end

         always_comb begin
            w_shift = r_q[gi];
            case (w_npop)
               2'd1:    w_shift = w_sh1;
               2'd2:    w_shift = w_sh2;
               default: w_shift = r_q[gi];
            endcase
         end

         always_comb begin
            w_qnext[gi] = w_shift;
            if (3'(gi) < w_rem) begin
               w_qnext[gi] = w_shift;
            end else if (3'(gi) == w_rem && w_npush != 2'd0) begin
               w_qnext[gi] = w_push0;
            end else if (3'(gi) == w_rem_p1 && w_npush == 2'd2) begin
               w_qnext[gi] = w_push1;
            end
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_q[gi] <= 17'h0;
            end else if (!flush_i) begin
               r_q[gi] <= w_qnext[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_count <= 3'd0;
         r_pc    <= {RESET_VECTOR[XLEN-1:1], 1'b0};
         r_drop  <= RESET_VECTOR[1];
      end else if (flush_i) begin
         r_count <= 3'd0;
         r_pc    <= {flush_pc_i[XLEN-1:1], 1'b0};
         r_drop  <= flush_pc_i[1];
      end else begin
         r_count <= w_rem + {1'b0, w_npush};
         if (w_pop) begin
            r_pc <= r_pc + ((w_cons == 2'd2) ? XLEN'(4) : XLEN'(2));
         end
         if (w_push) begin
            r_drop <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_align.sv
module tb_fetch_align;

   typedef struct packed {
      logic [15:0] d;
      logic        e;
   } hw_t;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        fetch_valid_i;
   logic [31:0] fetch_data_i;
   logic        fetch_err_i;
   logic        fetch_ready_o;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        is_comp_o;
   logic        inst_err_o;

   fetch_align dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .fetch_valid_i (fetch_valid_i),
      .fetch_data_i  (fetch_data_i),
      .fetch_err_i   (fetch_err_i),
      .fetch_ready_o (fetch_ready_o),
      .flush_i       (flush_i),
      .flush_pc_i    (flush_pc_i),
      .inst_valid_o  (inst_valid_o),
      .inst_ready_i  (inst_ready_i),
      .inst_o        (inst_o),
      .pc_o          (pc_o),
      .is_comp_o     (is_comp_o),
      .inst_err_o    (inst_err_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a plain halfword queue plus PC and drop flag.
   hw_t         mq[$];
   logic [31:0] mpc;
   logic        mdrop;

   // Observed values of the most recent step.
   logic        o_valid, o_comp, o_err, o_ready;
   logic [31:0] o_inst, o_pc;

   // Previous-step context for the hold-stable check.
   logic        p_hold_ok = 1'b0;
   logic [31:0] p_inst, p_pc;
   logic        p_comp, p_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic fv, input logic [31:0] fd, input logic fe,
                       input logic fl, input logic [31:0] fpc, input logic ir);
      int          n;
      int          cons;
      logic        e_valid, e_comp, e_err, e_ready;
      logic [31:0] e_inst;
      @(negedge clk);
      fetch_valid_i = fv;
      fetch_data_i  = fd;
      fetch_err_i   = fe;
      flush_i       = fl;
      flush_pc_i    = fpc;
      inst_ready_i  = ir;
      #1;
      n      = mq.size();
      cons   = 0;
      e_inst = 32'h0;
      e_comp = 1'b0;
      e_err  = 1'b0;
      if (!fl && n >= 1) begin
         if (mq[0].d[1:0] != 2'b11) begin
            cons = 1; e_inst = {16'h0, mq[0].d}; e_comp = 1'b1; e_err = mq[0].e;
         end else if (n >= 2) begin
            cons = 2; e_inst = {mq[1].d, mq[0].d}; e_err = mq[0].e | mq[1].e;
         end else if (mq[0].e) begin
            cons = 1; e_inst = {16'h0, mq[0].d}; e_err = 1'b1;
         end
      end
      e_valid = (cons != 0);
      e_ready = (n <= 2);

      o_valid = inst_valid_o; o_inst = inst_o; o_pc = pc_o;
      o_comp  = is_comp_o;    o_err  = inst_err_o; o_ready = fetch_ready_o;

      check("valid", 32'(o_valid), 32'(e_valid));
      check("inst",  o_inst, e_inst);
      check("pc",    o_pc, mpc);
      check("comp",  32'(o_comp), 32'(e_comp));
      check("err",   32'(o_err), 32'(e_err));
      check("ready", 32'(o_ready), 32'(e_ready));
      check("cnt_max", 32'(dut.r_count <= 3'd4), 32'd1);
      if (p_hold_ok && !fl) begin
         check("hold_inst", o_inst, p_inst);
         check("hold_pc",   o_pc, p_pc);
         check("hold_comp", 32'(o_comp), 32'(p_comp));
         check("hold_err",  32'(o_err), 32'(p_err));
      end
      // A lone fault may legitimately become a full instruction once its
      // partner arrives, so it is excluded from the hold check.
      p_hold_ok = e_valid && !ir && !(cons == 1 && !e_comp);
      p_inst = o_inst; p_pc = o_pc; p_comp = o_comp; p_err = o_err;

      @(posedge clk);
      if (fl) begin
         mq.delete();
         mpc   = {fpc[31:1], 1'b0};
         mdrop = fpc[1];
      end else begin
         if (e_valid && ir) begin
            for (int k = 0; k < cons; k++) void'(mq.pop_front());
            mpc = mpc + 32'(2 * cons);
         end
         if (fv && e_ready) begin
            if (!mdrop) mq.push_back('{d: fd[15:0], e: fe});
            mq.push_back('{d: fd[31:16], e: fe});
            mdrop = 1'b0;
         end
      end
   endtask

   task automatic idle(input logic ir);
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, ir);
   endtask

   task automatic redirect(input logic [31:0] tgt);
      step(1'b0, 32'h0, 1'b0, 1'b1, tgt, 1'b0);
   endtask

   initial begin
      rst_i = 1'b1; fetch_valid_i = 1'b0; fetch_data_i = 32'h0; fetch_err_i = 1'b0;
      flush_i = 1'b0; flush_pc_i = 32'h0; inst_ready_i = 1'b0;
      mpc = 32'h8000_0000; mdrop = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_i = 1'b0;

      // Reset state
      idle(1'b0);
      check("rst_pc", o_pc, 32'h8000_0000);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_ready", 32'(o_ready), 32'd1);

      // 32-bit instruction, one cycle latency
      step(1'b1, 32'h0000_0513, 1'b0, 1'b0, 32'h0, 1'b1);
      check("t1_lat", 32'(o_valid), 32'd0);
      idle(1'b1);
      check("t1_inst", o_inst, 32'h0000_0513);
      check("t1_pc", o_pc, 32'h8000_0000);
      idle(1'b0);
      check("t1_pc4", o_pc, 32'h8000_0004);

      // Two compressed instructions in one word
      redirect(32'h8000_0000);
      step(1'b1, 32'h4501_4501, 1'b0, 1'b0, 32'h0, 1'b1);
      idle(1'b1);
      check("t2_a", o_inst, 32'h0000_4501);
      check("t2_apc", o_pc, 32'h8000_0000);
      idle(1'b1);
      check("t2_b", o_inst, 32'h0000_4501);
      check("t2_bpc", o_pc, 32'h8000_0002);
      check("t2_bcomp", 32'(o_comp), 32'd1);

      // Straddling 32-bit instruction
      redirect(32'h8000_0000);
      step(1'b1, 32'h0513_4501, 1'b0, 1'b0, 32'h0, 1'b1);
      idle(1'b1);
      check("t3_c", o_inst, 32'h0000_4501);
      idle(1'b1);
      check("t3_wait", 32'(o_valid), 32'd0);
      step(1'b1, 32'hABCD_0000, 1'b0, 1'b0, 32'h0, 1'b1);
      idle(1'b1);
      check("t3_inst", o_inst, 32'h0000_0513);
      check("t3_pc", o_pc, 32'h8000_0002);

      // Redirect to an odd halfword, with a same-cycle pop attempt
      step(1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h8000_0102, 1'b1);
      check("t4_fvalid", 32'(o_valid), 32'd0);
      step(1'b1, 32'h4505_FFFF, 1'b0, 1'b0, 32'h0, 1'b0);
      idle(1'b1);
      check("t4_inst", o_inst, 32'h0000_4505);
      check("t4_pc", o_pc, 32'h8000_0102);

      // Backpressure: fill to four, refuse, then drain in order
      redirect(32'h8000_0000);
      step(1'b1, 32'h4501_4501, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h4501_4501, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t5_rdy2", 32'(o_ready), 32'd1);
      step(1'b1, 32'h0000_0513, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t5_rdy4", 32'(o_ready), 32'd0);
      for (int k = 0; k < 4; k++) begin
         idle(1'b1);
         check("t5_drain", o_pc, 32'h8000_0000 + 32'(2 * k));
      end
      idle(1'b1);
      check("t5_empty", 32'(o_valid), 32'd0);

      // Faults: straddled instruction, then lone faulting halfword
      redirect(32'h8000_0000);
      step(1'b1, 32'h0513_4501, 1'b0, 1'b0, 32'h0, 1'b1);
      idle(1'b1);
      step(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0, 1'b0);
      idle(1'b1);
      check("t6_inst", o_inst, 32'h0013_0513);
      check("t6_err", 32'(o_err), 32'd1);
      redirect(32'h8000_0002);
      step(1'b1, 32'hFFFF_1111, 1'b1, 1'b0, 32'h0, 1'b0);
      idle(1'b1);
      check("t6_lone_v", 32'(o_valid), 32'd1);
      check("t6_lone_e", 32'(o_err), 32'd1);
      check("t6_lone_i", o_inst, 32'h0000_FFFF);

      // Randomized traffic against the queue model
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] d;
         d = $urandom;
         step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 24) == 0), ($urandom & 32'hFFFF_FFFE),
              ($urandom_range(0, 2) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
